// File: rtl/iir_filter_threefold.sv
// iir_filter_threefold: 3-folded 2nd-order IIR section, Q10.10, one MAC.
// Define IIR_SAT_EN for a saturating output; the default build wraps.
module iir_filter_threefold #(
    parameter int W    = 20,
    parameter int FRAC = 10,
    parameter int B0   = 512,
    parameter int A1   = 256,
    parameter int A2   = -128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         y_valid
);

    localparam int AW = 2*W+2;

    localparam logic signed [W-1:0] B0C = W'(B0);
    localparam logic signed [W-1:0] A1C = W'(A1);
    localparam logic signed [W-1:0] A2C = W'(A2);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    phase_t phase;
    phase_t phase_nx;

    logic signed [W-1:0]    x_reg;
    logic signed [W-1:0]    y1;
    logic signed [W-1:0]    y2;
    logic signed [AW-1:0]   acc;
    logic signed [W-1:0]    m_c;
    logic signed [W-1:0]    m_d;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   sum;
    logic signed [W-1:0]    fit_r;
    logic                   unused_bits;

    // Phase register: 0 -> 1 -> 2 -> 0, forced to 0 by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH0;
        end else begin
            phase <= phase_nx;
        end
    end

    // Next-phase logic
    always_comb begin
        phase_nx = PH0;
        unique case (phase)
            PH0:     phase_nx = PH1;
            PH1:     phase_nx = PH2;
            default: phase_nx = PH0;
        endcase
    end

    // Shared multiplier operand mux: (B0,x) / (A1,y1) / (A2,y2)
    always_comb begin
        m_c = B0C;
        m_d = $signed(x);
        unique case (phase)
            PH0: begin
                m_c = B0C;
                m_d = $signed(x);
            end
            PH1: begin
                m_c = A1C;
                m_d = y1;
            end
            PH2: begin
                m_c = A2C;
                m_d = y2;
            end
            default: begin
                m_c = B0C;
                m_d = $signed(x);
            end
        endcase
    end

    assign prod     = m_c * m_d;
    assign prod_ext = {{2{prod[2*W-1]}}, prod};
    assign sum      = acc + prod_ext;

`ifdef IIR_SAT_EN
    localparam int HW = AW - (W+FRAC-1);

    logic [HW-1:0] hi;
    logic          ovf;

    assign hi  = sum[AW-1:W+FRAC-1];
    assign ovf = ~((&hi) | ~(|hi));

    // Clamp the shifted sum to the W-bit signed range
    always_comb begin
        fit_r = sum[W+FRAC-1:FRAC];
        if (ovf) begin
            fit_r = sum[AW-1] ? {1'b1, {(W-1){1'b0}}}
                              : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign unused_bits = ^{x_reg, sum[FRAC-1:0]};
`else
    assign fit_r = sum[W+FRAC-1:FRAC];

    assign unused_bits = ^{x_reg, sum[AW-1:W+FRAC], sum[FRAC-1:0]};
`endif

    // Datapath: load, accumulate, then shift/fit and update history
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg   <= '0;
            y1      <= '0;
            y2      <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            unique case (phase)
                PH0: begin
                    x_reg <= $signed(x);
                    acc   <= prod_ext;
                end
                PH1: begin
                    acc <= sum;
                end
                PH2: begin
                    y       <= fit_r;
                    y1      <= fit_r;
                    y2      <= y1;
                    y_valid <= 1'b1;
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_filter_threefold.sv
// tb_iir_filter_threefold: directed checks of the folded IIR section.
// Expected outputs are hand-computed Q10.10 values.
module tb_iir_filter_threefold;

    logic        clk;
    logic        rst;
    logic [19:0] x;
    logic [19:0] xo;
    logic [19:0] y;
    logic [19:0] yo;
    logic        y_valid;
    logic        yo_valid;

    int checks;
    int errors;

    iir_filter_threefold dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .y_valid (y_valid)
    );

    iir_filter_threefold #(.B0(4095)) dut_ovf (
        .clk     (clk),
        .rst     (rst),
        .x       (xo),
        .y       (yo),
        .y_valid (yo_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic ev;
        x  = 20'h0;
        xo = 20'h0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (y !== 20'h0) begin
            errors++;
            $display("FAIL reset_y: got %0h expected 0", y);
        end
        checks++;
        if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", y_valid);
        end
        checks++;
        if (yo !== 20'h0 || yo_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %0h/%0b expected 0/0",
                     yo, yo_valid);
        end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < 3; p++) begin
                tick();
                ev = (p == 2);
                checks++;
                if (y_valid !== ev) begin
                    errors++;
                    $display("FAIL zero_valid n%0d p%0d: got %0b expected %0b",
                             n, p, y_valid, ev);
                end
                checks++;
                if (y !== 20'h0) begin
                    errors++;
                    $display("FAIL zero_y n%0d p%0d: got %0h expected 0",
                             n, p, y);
                end
            end
        end
    endtask

    task automatic test_step();
        int exp_tab [8];
        logic [19:0] prev;
        exp_tab = '{256, 320, 304, 292, 291, 292, 292, 292};
        x = 20'h0;
        do_reset();
        x = 20'h00200;
        prev = 20'h0;
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < 2; p++) begin
                tick();
                checks++;
                if (y_valid !== 1'b0 || y !== prev) begin
                    errors++;
                    $display("FAIL step_hold n%0d p%0d: got %0h/%0b expected %0h/0",
                             n, p, y, y_valid, prev);
                end
            end
            tick();
            checks++;
            if (y_valid !== 1'b1 || y !== 20'(exp_tab[n])) begin
                errors++;
                $display("FAIL step_y n%0d: got %0d/%0b expected %0d/1",
                         n, $signed(y), y_valid, exp_tab[n]);
            end
            prev = 20'(exp_tab[n]);
        end
    endtask

    task automatic test_impulse();
        int exp_tab [10];
        exp_tab = '{512, 128, -32, -24, -2, 2, 0, -1, -1, -1};
        x = 20'h0;
        do_reset();
        x = 20'h00400;
        for (int n = 0; n < 10; n++) begin
            tick();
            x = 20'h0;
            tick();
            tick();
            checks++;
            if (y_valid !== 1'b1 || y !== 20'(exp_tab[n])) begin
                errors++;
                $display("FAIL impulse_y n%0d: got %0d/%0b expected %0d/1",
                         n, $signed(y), y_valid, exp_tab[n]);
            end
        end
    endtask

    task automatic test_sampling_window();
        x = 20'h0;
        do_reset();
        x = 20'h00200;
        tick();
        x = 20'h7FFFF;
        tick();
        tick();
        checks++;
        if (y_valid !== 1'b1 || y !== 20'd256) begin
            errors++;
            $display("FAIL window_y: got %0d/%0b expected 256/1",
                     $signed(y), y_valid);
        end
        x = 20'h0;
    endtask

    task automatic test_overflow();
        logic [19:0] exp_y;
`ifdef IIR_SAT_EN
        exp_y = 20'h7FFFF;
`else
        exp_y = 20'hFFF00;
`endif
        x  = 20'h0;
        xo = 20'h0;
        do_reset();
        xo = 20'h40000;
        tick();
        xo = 20'h0;
        tick();
        tick();
        checks++;
        if (yo_valid !== 1'b1 || yo !== exp_y) begin
            errors++;
            $display("FAIL overflow_y: got %0h/%0b expected %0h/1",
                     yo, yo_valid, exp_y);
        end
    endtask

    task automatic test_reset_mid();
        int exp_tab [2];
        exp_tab = '{256, 320};
        x = 20'h0;
        do_reset();
        x = 20'h00200;
        for (int n = 0; n < 2; n++) begin
            tick();
            tick();
            tick();
            checks++;
            if (y !== 20'(exp_tab[n])) begin
                errors++;
                $display("FAIL mid_pre n%0d: got %0d expected %0d",
                         n, $signed(y), exp_tab[n]);
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (y !== 20'h0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_y: got %0h/%0b expected 0/0",
                     y, y_valid);
        end
        checks++;
        if (dut.y1 !== 20'sh0 || dut.y2 !== 20'sh0) begin
            errors++;
            $display("FAIL mid_rst_hist: got %0h/%0h expected 0/0",
                     dut.y1, dut.y2);
        end
        for (int n = 0; n < 2; n++) begin
            tick();
            tick();
            tick();
            checks++;
            if (y_valid !== 1'b1 || y !== 20'(exp_tab[n])) begin
                errors++;
                $display("FAIL mid_restart n%0d: got %0d/%0b expected %0d/1",
                         n, $signed(y), y_valid, exp_tab[n]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        x   = 20'h0;
        xo  = 20'h0;
        test_reset();
        test_step();
        test_impulse();
        test_sampling_window();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
